// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: data width, RISC-V load/store
// access codes and the arbiter FSM encoding.
package mem_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic for data accesses: byte enables, store-lane replication,
// load extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign rd_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {(XLEN/8){wdata_i[7:0]}};
                rdata_o = (funct3_i == F3_B) ? {{(XLEN-8){rd_byte[7]}}, rd_byte}
                                             : {{(XLEN-8){1'b0}}, rd_byte};
            end
            F3_H, F3_HU: begin
                be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o      = {(XLEN/16){wdata_i[15:0]}};
                rdata_o      = (funct3_i == F3_H) ? {{(XLEN-16){rd_half[15]}}, rd_half}
                                                  : {{(XLEN-16){1'b0}}, rd_half};
                misaligned_o = addr_lo_i[0];
            end
            default: misaligned_o = (addr_lo_i != 2'b00);
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between instruction fetch and the data
// stage: arbitration, req/ack handshake, lane steering, misalignment and timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int FAIR           = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_ack,
    output logic [XLEN-1:0] o_if_data,
    input  logic            i_d_req,
    input  logic [XLEN-1:0] i_d_addr,
    input  logic            i_d_we,
    input  logic [2:0]      i_d_funct3,
    input  logic [XLEN-1:0] i_d_wdata,
    output logic            o_d_ack,
    output logic [XLEN-1:0] o_d_rdata,
    output logic            o_d_misaligned,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_we,
    output logic [3:0]      o_mem_be,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [XLEN-1:0]  WORD_MASK = ~XLEN'(3);

    state_e           state_q;
    grant_e           last_gnt_q;
    logic [1:0]       addr_lo_q;
    logic [2:0]       funct3_q;
    logic             we_q;
    logic [CNT_W-1:0] tmo_cnt_q;

    logic             mem_req_q;
    logic [XLEN-1:0]  mem_addr_q;
    logic             mem_we_q;
    logic [3:0]       mem_be_q;
    logic [XLEN-1:0]  mem_wdata_q;
    logic             if_ack_q;
    logic [XLEN-1:0]  if_data_q;
    logic             d_ack_q;
    logic [XLEN-1:0]  d_rdata_q;
    logic             d_mis_q;
    logic             tmo_err_q;

    logic             in_idle;
    logic             grant_d;
    logic             tmo_hit;
    logic [2:0]       al_funct3;
    logic [1:0]       al_addr_lo;
    logic [3:0]       al_be;
    logic [XLEN-1:0]  al_wdata;
    logic [XLEN-1:0]  al_rdata;
    logic             al_mis;

    // The aligner looks at the live request while arbitrating and at the latched fields once granted.
    assign in_idle    = (state_q == ST_IDLE);
    assign al_funct3  = in_idle ? i_d_funct3 : funct3_q;
    assign al_addr_lo = in_idle ? i_d_addr[1:0] : addr_lo_q;

    assign grant_d = i_d_req && !(i_if_req && (FAIR != 0) && (last_gnt_q == GNT_D));
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .wdata_i      (i_d_wdata),
        .rdata_i      (i_mem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis)
    );

    // NOTE: asynchronous reset so o_mem_req drops the moment i_rst_n falls, abandoning any bus transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= GNT_IF;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            tmo_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_data_q   <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_mis_q     <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values of the others.
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            d_mis_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        last_gnt_q <= GNT_D;
                        addr_lo_q  <= i_d_addr[1:0];
                        funct3_q   <= i_d_funct3;
                        we_q       <= i_d_we;
                        if (al_mis) begin
                            state_q   <= ST_RESP;
                            d_ack_q   <= 1'b1;
                            d_mis_q   <= 1'b1;
                            d_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_BUSY_D;
                            tmo_cnt_q   <= '0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= i_d_addr & WORD_MASK;
                            mem_we_q    <= i_d_we;
                            mem_be_q    <= al_be;
                            mem_wdata_q <= i_d_we ? al_wdata : '0;
                        end
                    end else if (i_if_req) begin
                        last_gnt_q  <= GNT_IF;
                        state_q     <= ST_BUSY_IF;
                        tmo_cnt_q   <= '0;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= i_if_addr & WORD_MASK;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b1111;
                        mem_wdata_q <= '0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_D: begin
                    // An ack on the timeout edge still counts as a normal completion.
                    if (i_mem_ack || tmo_hit) begin
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        tmo_err_q <= !i_mem_ack;
                        if (state_q == ST_BUSY_IF) begin
                            if_ack_q  <= 1'b1;
                            if_data_q <= i_mem_ack ? i_mem_rdata : '0;
                        end else begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= (i_mem_ack && !we_q) ? al_rdata : '0;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_mem_req      = mem_req_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_we       = mem_we_q;
    assign o_mem_be       = mem_be_q;
    assign o_mem_wdata    = mem_wdata_q;
    assign o_if_ack       = if_ack_q;
    assign o_if_data      = if_data_q;
    assign o_d_ack        = d_ack_q;
    assign o_d_rdata      = d_rdata_q;
    assign o_d_misaligned = d_mis_q;
    assign o_timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a bus responder with random latency,
// a request driver that predicts grant order, and a monitor checking completions.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int T = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        to;
        logic [31:0] rdata;
    } out_t;

    typedef struct packed {
        logic        mis;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
    } dreq_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        i_d_req = 1'b0;
    logic [31:0] i_d_addr = '0;
    logic        i_d_we = 1'b0;
    logic [2:0]  i_d_funct3 = '0;
    logic [31:0] i_d_wdata = '0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_if_ack, o_d_ack, o_d_misaligned, o_mem_req, o_mem_we, o_timeout_err;
    logic [31:0] o_if_data, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int          n_checks = 0;
    int          n_fail = 0;
    int          force_lat = -1;
    logic [31:0] force_rdata = '0;
    bit          last_was_d = 1'b0;

    logic [31:0] exp_if_q[$];
    dreq_t       exp_d_q[$];
    bus_t        exp_bus_q[$];
    out_t        bus_out_q[$];

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.XLEN(32), .FAIR(1), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack), .o_if_data(o_if_data),
        .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_we(i_d_we), .i_d_funct3(i_d_funct3),
        .i_d_wdata(i_d_wdata), .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
        .o_d_misaligned(o_d_misaligned), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_timeout_err(o_timeout_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes from the low funct3 bits, arithmetic on addresses.
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_steer(input logic [2:0] f3, input logic [31:0] wd);
        int sz = m_size(f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_extract(input logic [31:0] rd, input logic [2:0] f3,
                                              input logic [31:0] a);
        int     sz = m_size(f3);
        longint v;
        if (sz == 4) return rd;
        v = longint'(rd >> (8 * (a % 4))) & ((longint'(1) << (8 * sz)) - 1);
        if (f3[2] == 1'b0 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic logic [2:0] pick_f3(input bit we, input int r);
        if (we) begin
            case (r % 3)
                0: return F3_B;
                1: return F3_H;
                default: return F3_W;
            endcase
        end
        case (r % 5)
            0: return F3_B;
            1: return F3_H;
            2: return F3_W;
            3: return F3_BU;
            default: return F3_HU;
        endcase
    endfunction

    // Bus responder: checks each new bus request against the predicted order, holds it
    // stable, acks after a random latency (or never, forcing a timeout) and injects stray acks.
    initial begin : responder
        bus_t        cur;
        out_t        o;
        logic [31:0] rd;
        int          k, lat;
        bit          busy, wait_drop;
        cur = '0; k = 0; lat = 0; busy = 1'b0; wait_drop = 1'b0;
        forever begin
            @(negedge i_clk);
            i_mem_ack = 1'b0;
            if (wait_drop) begin
                check("bus_req_drop", 32'(o_mem_req), 32'd0);
                wait_drop = 1'b0;
            end else if (!busy && o_mem_req) begin
                check("bus_req_expected", 32'(exp_bus_q.size() != 0), 32'd1);
                if (exp_bus_q.size() != 0) begin
                    cur  = exp_bus_q.pop_front();
                    busy = 1'b1;
                    k    = 0;
                    lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, T + 1));
                end
            end
            if (busy) begin
                check("bus_req_held", 32'(o_mem_req), 32'd1);
                check("bus_addr", o_mem_addr, cur.addr);
                check("bus_we", 32'(o_mem_we), 32'(cur.we));
                check("bus_be", 32'(o_mem_be), 32'(cur.be));
                if (cur.we) check("bus_wdata", o_mem_wdata, cur.wdata);
                if (k == lat && lat < T) begin
                    rd          = (force_lat >= 0) ? force_rdata : $urandom;
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = rd;
                    o.to = 1'b0; o.rdata = rd;
                    bus_out_q.push_back(o);
                    busy = 1'b0; wait_drop = 1'b1;
                end else if (k == T - 1) begin
                    o.to = 1'b1; o.rdata = '0;
                    bus_out_q.push_back(o);
                    busy = 1'b0; wait_drop = 1'b1;
                end
                k++;
            end else if (!o_mem_req && $urandom_range(0, 3) == 0) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = $urandom;
            end
        end
    end

    // Completion monitor: pops the predicted response whenever a requester ack appears.
    initial begin : monitor
        dreq_t e;
        out_t  o;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_if_ack) begin
                    check("if_ack_expected", 32'(exp_if_q.size()), 32'd1);
                    check("if_bus_outcome", 32'(bus_out_q.size()), 32'd1);
                    if (exp_if_q.size() != 0 && bus_out_q.size() != 0) begin
                        void'(exp_if_q.pop_front());
                        o = bus_out_q.pop_front();
                        check("if_data", o_if_data, o.to ? 32'd0 : o.rdata);
                        check("if_timeout_err", 32'(o_timeout_err), 32'(o.to));
                    end
                end
                if (o_d_ack) begin
                    check("d_ack_expected", 32'(exp_d_q.size()), 32'd1);
                    if (exp_d_q.size() != 0) begin
                        e = exp_d_q.pop_front();
                        check("d_misaligned", 32'(o_d_misaligned), 32'(e.mis));
                        if (e.mis) begin
                            check("d_rdata_misaligned", o_d_rdata, 32'd0);
                            check("d_timeout_err_mis", 32'(o_timeout_err), 32'd0);
                        end else begin
                            check("d_bus_outcome", 32'(bus_out_q.size()), 32'd1);
                            if (bus_out_q.size() != 0) begin
                                o = bus_out_q.pop_front();
                                check("d_timeout_err", 32'(o_timeout_err), 32'(o.to));
                                if (!e.we)
                                    check("d_rdata", o_d_rdata,
                                          o.to ? 32'd0 : m_extract(o.rdata, e.f3, e.addr));
                            end
                        end
                    end
                end
                if (!o_if_ack && !o_d_ack)
                    check("stray_pulse", 32'({o_timeout_err, o_d_misaligned}), 32'd0);
            end
        end
    end

    // One transaction round: predict grant order, raise the requests together, hold each
    // until its ack, and scramble fields of a lone granted request to prove they were latched.
    task automatic txn(input bit do_if, input logic [31:0] ia, input bit do_d,
                       input logic [31:0] da, input bit dwe, input logic [2:0] df3,
                       input logic [31:0] dwd);
        bus_t  b_if, b_d;
        dreq_t e;
        bit    d_first, if_pend, d_pend, single;
        int    budget;
        @(negedge i_clk);
        b_if.addr = ia & 32'hFFFF_FFFC; b_if.we = 1'b0; b_if.be = 4'hF; b_if.wdata = '0;
        e.mis = m_misaligned(df3, da); e.we = dwe; e.f3 = df3; e.addr = da;
        b_d.addr = da & 32'hFFFF_FFFC; b_d.we = dwe; b_d.be = m_be(df3, da);
        b_d.wdata = m_steer(df3, dwd);
        d_first = do_d && (!do_if || !last_was_d);
        if (d_first && !e.mis) exp_bus_q.push_back(b_d);
        if (do_if) exp_bus_q.push_back(b_if);
        if (do_d && !d_first && !e.mis) exp_bus_q.push_back(b_d);
        last_was_d = (do_if && do_d) ? !d_first : do_d;
        if (do_if) exp_if_q.push_back(ia);
        if (do_d) exp_d_q.push_back(e);
        i_if_req = do_if; i_if_addr = ia;
        i_d_req = do_d; i_d_addr = da; i_d_we = dwe; i_d_funct3 = df3; i_d_wdata = dwd;
        if_pend = do_if; d_pend = do_d; single = !(do_if && do_d); budget = 0;
        while ((if_pend || d_pend) && budget < 40) begin
            @(negedge i_clk);
            budget++;
            if (single && budget == 1) begin
                if (do_d && e.mis) begin
                    check("mis_ack_latency", 32'(o_d_ack), 32'd1);
                    check("mis_no_bus", 32'(o_mem_req), 32'd0);
                end else begin
                    check("req_to_bus_latency", 32'(o_mem_req), 32'd1);
                end
            end
            if (if_pend && o_if_ack) begin if_pend = 1'b0; i_if_req = 1'b0; end
            if (d_pend && o_d_ack) begin d_pend = 1'b0; i_d_req = 1'b0; end
            if (single && (if_pend || d_pend)) begin
                i_if_addr = $urandom; i_d_addr = $urandom; i_d_we = 1'($urandom_range(0, 1));
                i_d_funct3 = 3'($urandom); i_d_wdata = $urandom;
            end
        end
        check("txn_complete", 32'({if_pend, d_pend}), 32'd0);
        i_if_req = 1'b0; i_d_req = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog no summary after 2 ms");
        $fatal(1, "bench did not terminate");
    end

    initial begin : main
        bit          di, dd, we;
        logic [31:0] ia, da;
        repeat (3) @(negedge i_clk);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_mem_be", 32'(o_mem_be), 32'd0);
        check("rst_if_ack", 32'(o_if_ack), 32'd0);
        check("rst_d_ack", 32'(o_d_ack), 32'd0);
        check("rst_d_rdata", o_d_rdata, 32'd0);
        check("rst_err_flags", 32'({o_timeout_err, o_d_misaligned}), 32'd0);
        i_rst_n = 1'b1;

        force_lat = 1; force_rdata = 32'h0000_0013;
        txn(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, F3_W, 32'h0);
        force_lat = -1;
        txn(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, F3_W, 32'h0);
        txn(1'b1, 32'h204, 1'b1, 32'h304, 1'b1, F3_W, 32'hCAFE_F00D);
        force_lat = 0; force_rdata = 32'h80FF_FF00;
        txn(1'b0, 32'h0, 1'b1, 32'h203, 1'b0, F3_B, 32'h0);
        txn(1'b0, 32'h0, 1'b1, 32'h203, 1'b0, F3_BU, 32'h0);
        txn(1'b0, 32'h0, 1'b1, 32'h202, 1'b0, F3_H, 32'h0);
        force_lat = -1;
        txn(1'b0, 32'h0, 1'b1, 32'h402, 1'b1, F3_H, 32'h1234_ABCD);
        txn(1'b0, 32'h0, 1'b1, 32'h401, 1'b1, F3_B, 32'h0000_005A);
        txn(1'b0, 32'h0, 1'b1, 32'h101, 1'b0, F3_W, 32'h0);
        txn(1'b1, 32'h120, 1'b1, 32'h103, 1'b0, F3_HU, 32'h0);
        force_lat = 99;
        txn(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, F3_W, 32'h0);
        txn(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, F3_W, 32'h0);
        force_lat = T - 1; force_rdata = 32'h1357_9BDF;
        txn(1'b1, 32'h508, 1'b0, 32'h0, 1'b0, F3_W, 32'h0);
        force_lat = -1;

        for (int n = 0; n < 250; n++) begin
            di = 1'($urandom_range(0, 1));
            dd = di ? 1'($urandom_range(0, 1)) : 1'b1;
            we = 1'($urandom_range(0, 1));
            ia = $urandom & 32'h0000_FFFF;
            da = $urandom & 32'h0000_FFFF;
            txn(di, ia, dd, da, we, pick_f3(we, int'($urandom_range(0, 99))), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        @(negedge i_clk);
        force_lat = 99;
        exp_bus_q.delete();
        i_if_req = 1'b1; i_if_addr = 32'h600;
        @(posedge i_clk);
        #2;
        check("busy_before_reset", 32'(o_mem_req), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("reset_drops_req", 32'(o_mem_req), 32'd0);
        check("reset_clears_acks", 32'({o_if_ack, o_d_ack, o_timeout_err}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
